// File: rtl/kmeans_apb_pkg.sv
// rtl/kmeans_apb_pkg.sv - shared types for the K-means APB requester
package kmeans_apb_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 91;

  typedef enum logic [3:0] {
    internal_status = 4'd0,
    GO              = 4'd1,
    cent_1          = 4'd2,
    cent_2          = 4'd3,
    cent_3          = 4'd4,
    cent_4          = 4'd5,
    cent_5          = 4'd6,
    cent_6          = 4'd7,
    cent_7          = 4'd8,
    cent_8          = 4'd9,
    ram_addr        = 4'd10,
    ram_data        = 4'd11,
    first_ram_addr  = 4'd12,
    last_ram_addr   = 4'd13,
    threshold       = 4'd14
  } kmeans_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/kmeans_cmd_fifo.sv
// rtl/kmeans_cmd_fifo.sv - command FIFO with registered occupancy and ready flag
module kmeans_cmd_fifo
  import kmeans_apb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = apb_cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     pop_data_o,
  output logic empty_o,
  output logic ready_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q;
  logic          full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // ready is a register so it stays low for one edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/kmeans_apb_master.sv
// rtl/kmeans_apb_master.sv - queued APB requester for the K-means register file
module kmeans_apb_master
  import kmeans_apb_pkg::*;
#(
  parameter int addrWidth      = 9,
  parameter int dataWidth      = 91,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic [addrWidth-1:0] rsp_addr,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic                 write;
    logic [addrWidth-1:0] addr;
    logic [dataWidth-1:0] wdata;
  } cmd_t;

  apb_state_e           state_q, state_d;
  cmd_t                 push_cmd, head;
  logic                 fifo_empty, fifo_pop;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 psel_q, psel_d, penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [addrWidth-1:0] paddr_q, paddr_d;
  logic [dataWidth-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [addrWidth-1:0] rsp_addr_q, rsp_addr_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

  assign push_cmd = {cmd_write, cmd_addr, cmd_wdata};

  kmeans_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cmd_valid && cmd_ready),
    .push_data_i (push_cmd),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .empty_o     (fifo_empty),
    .ready_o     (cmd_ready)
  );

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          paddr_d  = head.addr;
          pwrite_d = head.write;
          pwdata_d = head.write ? head.wdata : '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        tcnt_d    = '0;
      end
      ST_ACCESS: begin
        // pready wins over the timeout when both land on the last allowed cycle
        if (pready || tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = pwrite_q;
          rsp_addr_d  = paddr_q;
          rsp_err_d   = !pready;
          rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
